hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised forwarding and hazard-detection unit for the 5-stage MIPS datapath. It sits beside the ID and EX stages and selects bypass data for NRD source operands per stage from EX/MM/WB and from a multi-cycle unit (MDU) result. It raises a single pipeline stall. A scoreboard FSM tracks one in-flight MDU operation of latency MDU_LAT, so consumers stall until its result is ready.

## Interface
- NRD, 2: source operands per stage (ID and EX); ≥1
- MDU_LAT, 8: MDU execute cycles; ≥1
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- oper_id, oper_ex, oper_mm  in  W_OPER each  operation codes per stage
- from_ex_regf/from_mm_regf/from_wb_regf  in  W_REGF each  stage destination register
- from_ex_data/from_mm_data/from_wb_data  in  W_DATA each  stage result
- into_id_src  in  NRD*W_REGF  ID sources, operand k at bits [k*5+:5]
- into_ex_src  in  NRD*W_REGF  EX sources, same packing
- id_dst  in  W_REGF  destination of instruction in ID
- flush  in  1  pipeline kill (exception/redirect)
- mdu_data  in  W_DATA  MDU result, valid during DONE
- stall  out  1  freeze IF/ID, bubble into EX
- fwd_id_hit / fwd_ex_hit  out  NRD each  per-operand bypass valid
- fwd_id_data / fwd_ex_data  out  NRD*W_DATA each  per-operand bypass data
- mdu_wb  out  1  registered; register-file write of mdu_data to mdu_regf this cycle
- mdu_regf  out  W_REGF  registered; latched MDU destination
- stall_cnt  out  32  stall-cycle counter (see Configuration)

## Operation
- Oper classes from oper[4:3]: 01 jump/branch, 10 memory, 11 MDU, 00 other.
- Register 0 never matches: no forwarding, no dependency, never scoreboarded.
- ID forward priority per operand: EX > MM > WB > MDU(DONE, mdu_regf). EX forward: MM > WB. No match -> hit 0, data 0.
- FSM states IDLE, BUSY, DONE; 4-bit-or-wider down-counter cnt (width clog2(MDU_LAT)+1).
- issue = (oper_id class 11) & ~stall & ~flush, legal in IDLE or DONE: next BUSY, cnt <= MDU_LAT-1, mdu_regf <= id_dst.
- BUSY: cnt decrements; cnt==0 -> DONE. DONE: mdu_wb=1 one cycle, then IDLE unless issue.
- stall = OR of, each with matching reg nonzero:
  - ID source == EX dest and ID is jump/branch
  - ID source == EX dest and EX is memory
  - ID source == MM dest and ID is jump/branch
  - BUSY and ID source == mdu_regf (RAW)
  - BUSY and id_dst == mdu_regf (WAW)
  - BUSY and ID is MDU class (structural)
- flush: FSM -> IDLE, mdu_wb cleared next cycle, issue suppressed; counter reset. A DONE-cycle writeback is not retracted.

## Timing
- Forward outputs and stall: combinational from inputs and registered state, same cycle.
- Issue at cycle t -> BUSY t+1..t+MDU_LAT -> DONE/mdu_wb at t+MDU_LAT+1.
- Dependent ID instruction stalls through BUSY, proceeds in DONE with MDU bypass.
- Back-to-back: MDU issue during DONE accepted; next BUSY starts following cycle.
- Reset: state IDLE, cnt 0, mdu_wb 0, mdu_regf 0, stall_cnt 0; stall and forward outputs then depend only on inputs.
- rst mid-BUSY: in-flight op abandoned, no mdu_wb.
- rst dominates flush; flush dominates issue.

## Configuration
- HAZARD_PERF_EN defined: stall_cnt increments each cycle stall=1, saturates at 32'hFFFF_FFFF, cleared by rst.
- Undefined: no counter logic; stall_cnt tied to 0.

## Structure
- Shared package/defines: W_OPER, W_REGF, W_DATA, oper-class constants (OPC_JB, OPC_MEM, OPC_MDU), FSM state encodings.
- One sub-module mdu_tracker: FSM, counter, mdu_regf latch, mdu_wb; exports busy/done/mdu_regf to the top.
- Top: NRD-wide generate loops for forward muxes and dependency terms.

## Test plan
- EX dest r5, ID src0 r5, oper_ex other -> fwd_id_hit[0]=1, data=from_ex_data; EX also r5 in MM -> EX wins; stall 0.
- EX lw to r3, ID add r3 -> stall 1; same with dest r0 -> stall 0, hit 0.
- ID beq on r4, MM dest r4 -> stall 1; WB dest r4 only -> stall 0, forwarded from WB.
- MDU_LAT=8: issue r7 at t; ID reads r7 -> stall t+1..t+8, mdu_wb=1 and fwd_id_data=mdu_data at t+9; second MDU op at t+9 accepted.
- flush at t+3 of BUSY -> IDLE at t+4, no mdu_wb; rst at t+5 of a new op -> no mdu_wb, all outputs at reset values.
- With HAZARD_PERF_EN: 10 stall cycles -> stall_cnt=10; preload near saturation -> holds 32'hFFFF_FFFF.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Shared widths, operation-class codes and MDU tracker state encoding for the
// forwarding / hazard-detection unit of the 5-stage MIPS datapath.
//   W_OPER / W_REGF / W_DATA : operation-code, register-index and data widths
//   OPC_*                    : operation class taken from oper[4:3]
//   mdu_state_e              : MDU tracker FSM states
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

  localparam int W_OPER = 5;
  localparam int W_REGF = 5;
  localparam int W_DATA = 32;

  localparam logic [1:0] OPC_OTHER = 2'b00;
  localparam logic [1:0] OPC_JB    = 2'b01;
  localparam logic [1:0] OPC_MEM   = 2'b10;
  localparam logic [1:0] OPC_MDU   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  // Operation class lives in the top two bits of the operation code.
  function automatic logic [1:0] oper_class(input logic [W_OPER-1:0] oper);
    return oper[4:3];
  endfunction

endpackage

// File: rtl/hazard_scoreboard_mdu_tracker.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_mdu_tracker
// Scoreboard for the single in-flight multi-cycle (MDU) operation.
// IDLE -> BUSY on issue (MDU_LAT cycles) -> DONE (one writeback cycle) -> IDLE,
// or straight back to BUSY when a new MDU op issues during DONE.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   issue        : accepted MDU issue from ID this cycle
//   flush        : pipeline kill, abandons any in-flight op
//   id_dst       : destination register of the issuing instruction
//   busy, done   : current FSM state decode (combinational from state)
//   mdu_wb       : registered; high for exactly the DONE cycle
//   mdu_regf     : registered; destination latched at issue
// -----------------------------------------------------------------------------
module hazard_scoreboard_mdu_tracker
  import hazard_scoreboard_pkg::*;
#(
  parameter int MDU_LAT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic              flush,
  input  logic [W_REGF-1:0] id_dst,
  output logic              busy,
  output logic              done,
  output logic              mdu_wb,
  output logic [W_REGF-1:0] mdu_regf
);

  localparam int W_CNT_RAW = $clog2(MDU_LAT) + 1;
  localparam int W_CNT     = (W_CNT_RAW < 4) ? 4 : W_CNT_RAW;
  localparam logic [W_CNT-1:0] CNT_LOAD = W_CNT'(MDU_LAT - 1);

  mdu_state_e        state_reg, state_next;
  logic [W_CNT-1:0]  cnt_reg, cnt_next;
  logic [W_REGF-1:0] mdu_regf_reg, mdu_regf_next;
  logic              mdu_wb_reg;

  // State register. mdu_wb is registered from the next state so it is high
  // exactly while the FSM sits in DONE; a flush steers the next state away
  // from DONE, so a pending writeback never appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      mdu_regf_reg <= '0;
      mdu_wb_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      mdu_regf_reg <= mdu_regf_next;
      mdu_wb_reg   <= (state_next == ST_DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    mdu_regf_next = mdu_regf_reg;
    if (flush) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (issue) begin
            state_next    = ST_BUSY;
            cnt_next      = CNT_LOAD;
            mdu_regf_next = id_dst;
          end
        end
        ST_BUSY: begin
          if (cnt_reg == '0) begin
            state_next = ST_DONE;
          end else begin
            cnt_next = cnt_reg - W_CNT'(1);
          end
        end
        ST_DONE: begin
          if (issue) begin
            state_next    = ST_BUSY;
            cnt_next      = CNT_LOAD;
            mdu_regf_next = id_dst;
          end else begin
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Output decode.
  always_comb begin
    busy     = (state_reg == ST_BUSY);
    done     = (state_reg == ST_DONE);
    mdu_wb   = mdu_wb_reg;
    mdu_regf = mdu_regf_reg;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Forwarding and hazard-detection unit beside the ID and EX stages.
// Per source operand it selects bypass data (ID: EX > MM > WB > MDU result,
// EX: MM > WB), raises one pipeline stall for load-use, branch-compare and
// MDU RAW/WAW/structural hazards, and tracks one in-flight MDU operation.
// Optional build macro: HAZARD_PERF_EN -- enables the saturating stall-cycle
// counter on stall_cnt; without it stall_cnt is constant zero.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   oper_id/oper_ex/oper_mm      : per-stage operation codes (class = [4:3])
//   from_{ex,mm,wb}_regf/_data   : stage destination register and result
//   into_id_src / into_ex_src    : NRD packed source registers per stage
//   id_dst                       : destination of the instruction in ID
//   flush                        : pipeline kill
//   mdu_data                     : MDU result, valid while mdu_wb is high
//   stall                        : freeze IF/ID, bubble into EX
//   fwd_id_hit/_data, fwd_ex_hit/_data : per-operand bypass select and data
//   mdu_wb, mdu_regf             : registered MDU writeback strobe and target
//   stall_cnt                    : stall-cycle counter
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NRD     = 2,
  parameter int MDU_LAT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W_OPER-1:0]     oper_id,
  input  logic [W_OPER-1:0]     oper_ex,
  input  logic [W_OPER-1:0]     oper_mm,
  input  logic [W_REGF-1:0]     from_ex_regf,
  input  logic [W_REGF-1:0]     from_mm_regf,
  input  logic [W_REGF-1:0]     from_wb_regf,
  input  logic [W_DATA-1:0]     from_ex_data,
  input  logic [W_DATA-1:0]     from_mm_data,
  input  logic [W_DATA-1:0]     from_wb_data,
  input  logic [NRD*W_REGF-1:0] into_id_src,
  input  logic [NRD*W_REGF-1:0] into_ex_src,
  input  logic [W_REGF-1:0]     id_dst,
  input  logic                  flush,
  input  logic [W_DATA-1:0]     mdu_data,
  output logic                  stall,
  output logic [NRD-1:0]        fwd_id_hit,
  output logic [NRD-1:0]        fwd_ex_hit,
  output logic [NRD*W_DATA-1:0] fwd_id_data,
  output logic [NRD*W_DATA-1:0] fwd_ex_data,
  output logic                  mdu_wb,
  output logic [W_REGF-1:0]     mdu_regf,
  output logic [31:0]           stall_cnt
);

  logic           id_is_jb, id_is_mdu, ex_is_mem;
  logic           mdu_busy, mdu_done, issue;
  logic           waw_dep, struct_dep;
  logic [NRD-1:0] raw_dep;

  assign id_is_jb  = (oper_class(oper_id) == OPC_JB);
  assign id_is_mdu = (oper_class(oper_id) == OPC_MDU);
  assign ex_is_mem = (oper_class(oper_ex) == OPC_MEM);

  // The MM-stage opcode and the low opcode bits carry no hazard information.
  logic unused_oper_bits;
  assign unused_oper_bits = ^{oper_mm, oper_id[2:0], oper_ex[2:0]};

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_opnd
      logic [W_REGF-1:0] id_src, ex_src;
      logic              id_hit, ex_hit;
      logic [W_DATA-1:0] id_data, ex_data;

      assign id_src = into_id_src[gi*W_REGF +: W_REGF];
      assign ex_src = into_ex_src[gi*W_REGF +: W_REGF];

      // ID bypass: the youngest producer wins; the MDU result is only a
      // candidate during its writeback cycle.
      always_comb begin
        id_hit  = 1'b0;
        id_data = '0;
        if (id_src != '0) begin
          if (id_src == from_ex_regf) begin
            id_hit  = 1'b1;
            id_data = from_ex_data;
          end else if (id_src == from_mm_regf) begin
            id_hit  = 1'b1;
            id_data = from_mm_data;
          end else if (id_src == from_wb_regf) begin
            id_hit  = 1'b1;
            id_data = from_wb_data;
          end else if (mdu_done && (id_src == mdu_regf)) begin
            id_hit  = 1'b1;
            id_data = mdu_data;
          end
        end
      end

      // EX bypass.
      always_comb begin
        ex_hit  = 1'b0;
        ex_data = '0;
        if (ex_src != '0) begin
          if (ex_src == from_mm_regf) begin
            ex_hit  = 1'b1;
            ex_data = from_mm_data;
          end else if (ex_src == from_wb_regf) begin
            ex_hit  = 1'b1;
            ex_data = from_wb_data;
          end
        end
      end

      // Dependencies that bypassing cannot cover: branch compares in ID need
      // the value before EX/MM produce it, a load in EX has no data yet, and
      // an MDU result is unavailable while the unit is busy.
      assign raw_dep[gi] = (id_src != '0) &&
                           (((id_src == from_ex_regf) && (id_is_jb || ex_is_mem)) ||
                            ((id_src == from_mm_regf) && id_is_jb) ||
                            (mdu_busy && (id_src == mdu_regf)));

      assign fwd_id_hit[gi]                  = id_hit;
      assign fwd_ex_hit[gi]                  = ex_hit;
      assign fwd_id_data[gi*W_DATA +: W_DATA] = id_data;
      assign fwd_ex_data[gi*W_DATA +: W_DATA] = ex_data;
    end
  endgenerate

  assign waw_dep    = mdu_busy && (id_dst != '0) && (id_dst == mdu_regf);
  assign struct_dep = mdu_busy && id_is_mdu;
  assign stall      = (|raw_dep) || waw_dep || struct_dep;

  // A busy unit always stalls an MDU op (structural), so issue only ever
  // fires from IDLE or DONE.
  assign issue = id_is_mdu && !stall && !flush;

  hazard_scoreboard_mdu_tracker #(
    .MDU_LAT (MDU_LAT)
  ) mdu_tracker (
    .clk      (clk),
    .rst      (rst),
    .issue    (issue),
    .flush    (flush),
    .id_dst   (id_dst),
    .busy     (mdu_busy),
    .done     (mdu_done),
    .mdu_wb   (mdu_wb),
    .mdu_regf (mdu_regf)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int NRD     = 2;
  localparam int MDU_LAT = 8;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [W_OPER-1:0]     oper_id, oper_ex, oper_mm;
  logic [W_REGF-1:0]     from_ex_regf, from_mm_regf, from_wb_regf;
  logic [W_DATA-1:0]     from_ex_data, from_mm_data, from_wb_data;
  logic [NRD*W_REGF-1:0] into_id_src, into_ex_src;
  logic [W_REGF-1:0]     id_dst;
  logic                  flush;
  logic [W_DATA-1:0]     mdu_data;
  logic                  stall;
  logic [NRD-1:0]        fwd_id_hit, fwd_ex_hit;
  logic [NRD*W_DATA-1:0] fwd_id_data, fwd_ex_data;
  logic                  mdu_wb;
  logic [W_REGF-1:0]     mdu_regf;
  logic [31:0]           stall_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NRD     (NRD),
    .MDU_LAT (MDU_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .oper_id      (oper_id),
    .oper_ex      (oper_ex),
    .oper_mm      (oper_mm),
    .from_ex_regf (from_ex_regf),
    .from_mm_regf (from_mm_regf),
    .from_wb_regf (from_wb_regf),
    .from_ex_data (from_ex_data),
    .from_mm_data (from_mm_data),
    .from_wb_data (from_wb_data),
    .into_id_src  (into_id_src),
    .into_ex_src  (into_ex_src),
    .id_dst       (id_dst),
    .flush        (flush),
    .mdu_data     (mdu_data),
    .stall        (stall),
    .fwd_id_hit   (fwd_id_hit),
    .fwd_ex_hit   (fwd_ex_hit),
    .fwd_id_data  (fwd_id_data),
    .fwd_ex_data  (fwd_ex_data),
    .mdu_wb       (mdu_wb),
    .mdu_regf     (mdu_regf),
    .stall_cnt    (stall_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the MDU is described by the cycle it issued in; it is
  // busy for the MDU_LAT cycles after that and writes back the cycle after.
  int               cyc;
  bit               m_active;
  int               m_issue_cyc;
  logic [W_REGF-1:0] m_regf;
  longint           m_scnt;

  logic                  e_stall, e_issue, e_busy, e_done;
  logic [NRD-1:0]        e_id_hit, e_ex_hit;
  logic [NRD*W_DATA-1:0] e_id_data, e_ex_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_idle();
    oper_id      = '0;  oper_ex      = '0;  oper_mm      = '0;
    from_ex_regf = '0;  from_mm_regf = '0;  from_wb_regf = '0;
    from_ex_data = 32'hE0E0_0001;
    from_mm_data = 32'hA0A0_0002;
    from_wb_data = 32'hB0B0_0003;
    into_id_src  = '0;  into_ex_src  = '0;
    id_dst       = '0;  flush        = 1'b0;
    mdu_data     = 32'hD0D0_0004;
  endtask

  // Evaluate the model for the current cycle and compare every output.
  task automatic settle();
    logic [W_REGF-1:0] s;
    logic [W_REGF-1:0] cand_r [4];
    logic [W_DATA-1:0] cand_d [4];
    logic [1:0]        cls_id, cls_ex;
    @(negedge clk);
    e_busy = m_active && (cyc >= m_issue_cyc + 1) && (cyc <= m_issue_cyc + MDU_LAT);
    e_done = m_active && (cyc == m_issue_cyc + MDU_LAT + 1);
    cls_id = oper_id[4:3];
    cls_ex = oper_ex[4:3];
    cand_r[0] = from_ex_regf;  cand_d[0] = from_ex_data;
    cand_r[1] = from_mm_regf;  cand_d[1] = from_mm_data;
    cand_r[2] = from_wb_regf;  cand_d[2] = from_wb_data;
    cand_r[3] = e_done ? m_regf : '0;  cand_d[3] = mdu_data;
    e_stall   = 1'b0;
    e_id_hit  = '0;  e_id_data = '0;
    e_ex_hit  = '0;  e_ex_data = '0;
    for (int k = 0; k < NRD; k++) begin
      s = into_id_src[k*W_REGF +: W_REGF];
      if (s != 0) begin
        for (int c = 3; c >= 0; c--) begin
          if (cand_r[c] == s) begin
            e_id_hit[k] = 1'b1;
            e_id_data[k*W_DATA +: W_DATA] = cand_d[c];
          end
        end
        if (cls_id == OPC_JB && (s == from_ex_regf || s == from_mm_regf)) e_stall = 1'b1;
        if (cls_ex == OPC_MEM && s == from_ex_regf) e_stall = 1'b1;
        if (e_busy && s == m_regf) e_stall = 1'b1;
      end
      s = into_ex_src[k*W_REGF +: W_REGF];
      if (s != 0) begin
        for (int c = 2; c >= 1; c--) begin
          if (cand_r[c] == s) begin
            e_ex_hit[k] = 1'b1;
            e_ex_data[k*W_DATA +: W_DATA] = cand_d[c];
          end
        end
      end
    end
    if (e_busy && id_dst != 0 && id_dst == m_regf) e_stall = 1'b1;
    if (e_busy && cls_id == OPC_MDU) e_stall = 1'b1;
    e_issue = (cls_id == OPC_MDU) && !e_stall && !flush;

    check("stall",       64'(stall),       64'(e_stall));
    check("fwd_id_hit",  64'(fwd_id_hit),  64'(e_id_hit));
    check("fwd_id_data", 64'(fwd_id_data), 64'(e_id_data));
    check("fwd_ex_hit",  64'(fwd_ex_hit),  64'(e_ex_hit));
    check("fwd_ex_data", 64'(fwd_ex_data), 64'(e_ex_data));
    check("mdu_wb",      64'(mdu_wb),      64'(e_done));
    check("mdu_regf",    64'(mdu_regf),    64'(m_regf));
    check("stall_cnt",   64'(stall_cnt),   PERF ? 64'(m_scnt) : 64'd0);
    $display("cyc=%0d rst=%b fl=%b op_id=%h id_src=%h id_dst=%0d stall=%b wb=%b regf=%0d",
             cyc, rst, flush, oper_id, into_id_src, id_dst, stall, mdu_wb, mdu_regf);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_active = 1'b0;
      m_regf   = '0;
      m_scnt   = 0;
    end else begin
      if (e_stall) m_scnt++;
      if (flush) m_active = 1'b0;
      else if (e_issue) begin
        m_active    = 1'b1;
        m_issue_cyc = cyc;
        m_regf      = id_dst;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;  m_active = 1'b0;  m_issue_cyc = -100;  m_regf = '0;  m_scnt = 0;

    // Reset state.
    settle();
    check("rst_mdu_wb", 64'(mdu_wb), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    advance();
    rst = 1'b0;

    // EX bypass of r5, MM also r5: EX wins.
    set_idle();
    from_ex_regf = 5'd5;  from_mm_regf = 5'd5;  into_id_src = {5'd0, 5'd5};
    settle();
    check("tp_ex_hit",   64'(fwd_id_hit[0]),   64'd1);
    check("tp_ex_data",  64'(fwd_id_data[31:0]), 64'h0000_0000_E0E0_0001);
    check("tp_ex_stall", 64'(stall), 64'd0);
    advance();

    // Load-use on r3 stalls; same with r0 does not.
    set_idle();
    oper_ex = 5'b10000;  from_ex_regf = 5'd3;  into_id_src = {5'd0, 5'd3};
    settle();
    check("tp_lw_stall", 64'(stall), 64'd1);
    advance();
    from_ex_regf = 5'd0;  into_id_src = '0;
    settle();
    check("tp_r0_stall", 64'(stall), 64'd0);
    check("tp_r0_hit",   64'(fwd_id_hit), 64'd0);
    advance();

    // Branch on r4 with MM producer stalls; WB producer is forwarded.
    set_idle();
    oper_id = 5'b01000;  from_mm_regf = 5'd4;  into_id_src = {5'd4, 5'd0};
    settle();
    check("tp_br_mm_stall", 64'(stall), 64'd1);
    advance();
    from_mm_regf = 5'd0;  from_wb_regf = 5'd4;
    settle();
    check("tp_br_wb_stall", 64'(stall), 64'd0);
    check("tp_br_wb_data",  64'(fwd_id_data[63:32]), 64'h0000_0000_B0B0_0003);
    advance();

    // MDU issue to r7 and a dependent reader.
    set_idle();
    oper_id = 5'b11000;  id_dst = 5'd7;
    settle();
    advance();
    oper_id = '0;  id_dst = '0;  into_id_src = {5'd0, 5'd7};
    for (int i = 1; i <= MDU_LAT; i++) begin
      settle();
      check("tp_mdu_raw_stall", 64'(stall), 64'd1);
      advance();
    end
    oper_id = 5'b11000;  id_dst = 5'd9;  mdu_data = 32'h1234_5678;
    settle();
    check("tp_mdu_done_stall", 64'(stall), 64'd0);
    check("tp_mdu_wb",         64'(mdu_wb), 64'd1);
    check("tp_mdu_bypass",     64'(fwd_id_data[31:0]), 64'h0000_0000_1234_5678);
    advance();
    // Back-to-back op accepted: now busy with r9.
    oper_id = '0;  id_dst = '0;  into_id_src = {5'd0, 5'd9};
    for (int i = 1; i <= 3; i++) begin
      flush = (i == 3);
      settle();
      check("tp_b2b_stall", 64'(stall), 64'd1);
      check("tp_b2b_regf",  64'(mdu_regf), 64'd9);
      advance();
    end
    flush = 1'b0;
    for (int i = 0; i < MDU_LAT; i++) begin
      settle();
      check("tp_flush_stall", 64'(stall), 64'd0);
      check("tp_flush_no_wb", 64'(mdu_wb), 64'd0);
      advance();
    end

    // Reset in the middle of a new op.
    set_idle();
    oper_id = 5'b11000;  id_dst = 5'd6;
    settle();
    advance();
    oper_id = '0;  id_dst = '0;  into_id_src = {5'd6, 5'd0};
    for (int i = 1; i <= 5; i++) begin
      rst = (i == 5);
      settle();
      advance();
    end
    rst = 1'b0;
    for (int i = 0; i < MDU_LAT; i++) begin
      settle();
      check("tp_rst_stall", 64'(stall), 64'd0);
      check("tp_rst_wb",    64'(mdu_wb), 64'd0);
      check("tp_rst_regf",  64'(mdu_regf), 64'd0);
      advance();
    end

    // Ten stall cycles.
    set_idle();
    oper_ex = 5'b10000;  from_ex_regf = 5'd3;  into_id_src = {5'd0, 5'd3};
    for (int i = 0; i < 10; i++) begin
      settle();
      advance();
    end
    set_idle();
    settle();
    check("tp_stall_cnt10", 64'(stall_cnt), PERF ? 64'd10 : 64'd0);
    advance();

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      oper_id      = W_OPER'($urandom);
      oper_ex      = W_OPER'($urandom);
      oper_mm      = W_OPER'($urandom);
      from_ex_regf = W_REGF'($urandom_range(0, 7));
      from_mm_regf = W_REGF'($urandom_range(0, 7));
      from_wb_regf = W_REGF'($urandom_range(0, 7));
      from_ex_data = $urandom;
      from_mm_data = $urandom;
      from_wb_data = $urandom;
      mdu_data     = $urandom;
      for (int k = 0; k < NRD; k++) begin
        into_id_src[k*W_REGF +: W_REGF] = W_REGF'($urandom_range(0, 7));
        into_ex_src[k*W_REGF +: W_REGF] = W_REGF'($urandom_range(0, 7));
      end
      id_dst = W_REGF'($urandom_range(0, 7));
      flush  = ($urandom_range(0, 15) == 0);
      rst    = ($urandom_range(0, 63) == 0);
      settle();
      advance();
    end
    rst = 1'b0;
    set_idle();
    settle();
    advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
